// File: rtl/reg_bank_fetch.sv
// reg_bank_fetch: register bank with PC-aliased entry and bypassed reads,
// plus PC sequencer and loadable instruction memory with registered fetch.
module reg_bank_fetch #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int NUM_RD = 3,
  parameter int PC_IDX = 15,
  parameter int PC_READ_OFS = 8,
  parameter int IMEM_AW = 8,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     fetch_en,
  input  logic                     branch_valid,
  input  logic [DATA_W-1:0]        branch_target,
  input  logic                     imem_we,
  input  logic [IMEM_AW-1:0]       imem_waddr,
  input  logic [DATA_W-1:0]        imem_wdata,
  output logic                     inst_valid,
  output logic [DATA_W-1:0]        inst,
  output logic [DATA_W-1:0]        inst_pc,
  output logic [DATA_W-1:0]        pc
);

  localparam int NREG = 1 << ADDR_W;
  localparam int NWORD = 1 << IMEM_AW;
  localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);
  localparam logic [DATA_W-1:0] RD_OFS = DATA_W'(PC_READ_OFS);
  localparam logic [DATA_W-1:0] STEP = DATA_W'(4);
  localparam logic [DATA_W-1:0] ALIGN = {{(DATA_W-2){1'b1}}, 2'b00};

  logic [DATA_W-1:0]  regs [NREG];
  logic [DATA_W-1:0]  imem [NWORD];

  logic [DATA_W-1:0]  pc_q;
  logic [DATA_W-1:0]  inst_q;
  logic [DATA_W-1:0]  inst_pc_q;
  logic               valid_q;

  logic               pc_wr;
  logic               redir;
  logic               seq;
  logic [DATA_W-1:0]  redir_pc;
  logic [DATA_W-1:0]  pc_ofs;
  logic [IMEM_AW-1:0] fetch_idx;
  logic [DATA_W-1:0]  fetch_word;

  assign pc_wr      = wr_en && (wr_addr == PC_A);
  assign pc_ofs     = pc_q + RD_OFS;
  assign fetch_idx  = pc_q[IMEM_AW+1:2];
  assign fetch_word = imem[fetch_idx];

  // Pick this cycle's PC action: branch beats PC write beats fetch.
  always_comb begin
    redir    = branch_valid | pc_wr;
    redir_pc = (branch_valid ? branch_target : wr_data) & ALIGN;
    seq      = !redir && fetch_en;
  end

  // Read ports: PC alias, then write-through bypass, then array.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (rd_addr[k*ADDR_W +: ADDR_W] == PC_A) begin
        rd_data[k*DATA_W +: DATA_W] = pc_ofs;
      end else if (wr_en &&
                   wr_addr == rd_addr[k*ADDR_W +: ADDR_W]) begin
        rd_data[k*DATA_W +: DATA_W] = wr_data;
      end else begin
        rd_data[k*DATA_W +: DATA_W] =
          regs[rd_addr[k*ADDR_W +: ADDR_W]];
      end
    end
  end

  // Register array; the PC-aliased slot is never written.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en && !pc_wr) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Instruction memory load; contents survive reset, reads see old data.
  always_ff @(posedge clk) begin
    if (imem_we) imem[imem_waddr] <= imem_wdata;
  end

  // PC sequencer and registered fetch stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      valid_q   <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      unique case (1'b1)
        redir: begin
          pc_q    <= redir_pc;
          valid_q <= 1'b0;
        end
        seq: begin
          inst_q    <= fetch_word;
          inst_pc_q <= pc_q;
          valid_q   <= 1'b1;
          pc_q      <= pc_q + STEP;
        end
        default: ;
      endcase
    end
  end

  assign pc         = pc_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = valid_q;

endmodule

// File: tb/tb_reg_bank_fetch.sv
// tb_reg_bank_fetch: directed plus random checks of reg_bank_fetch
// against a behavioural model of the register bank and fetch unit.
module tb_reg_bank_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] rd_addr;
  logic [95:0] rd_data;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        fetch_en;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic        imem_we;
  logic [7:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] pc;

  int ncmp = 0;
  int nerr = 0;

  logic [31:0] m_regs [16];
  logic [31:0] m_imem [256];
  logic [31:0] m_pc, m_inst, m_ipc;
  logic        m_valid;

  reg_bank_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .fetch_en(fetch_en),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata),
    .inst_valid(inst_valid), .inst(inst),
    .inst_pc(inst_pc), .pc(pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [3:0] a);
    if (a == 4'd15) return m_pc + 32'd8;
    if (wr_en && wr_addr == a) return wr_data;
    return m_regs[a];
  endfunction

  task automatic model_reset();
    m_pc = 32'd0; m_valid = 1'b0; m_inst = 32'd0; m_ipc = 32'd0;
    for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
  endtask

  task automatic model_edge();
    logic [31:0] old_word;
    old_word = m_imem[m_pc[9:2]];
    if (!rst_n) begin
      model_reset();
    end else begin
      if (wr_en && wr_addr != 4'd15) m_regs[wr_addr] = wr_data;
      if (branch_valid) begin
        m_pc = {branch_target[31:2], 2'b00};
        m_valid = 1'b0;
      end else if (wr_en && wr_addr == 4'd15) begin
        m_pc = {wr_data[31:2], 2'b00};
        m_valid = 1'b0;
      end else if (fetch_en) begin
        m_inst = old_word;
        m_ipc = m_pc;
        m_valid = 1'b1;
        m_pc = m_pc + 32'd4;
      end
    end
    if (imem_we) m_imem[imem_waddr] = imem_wdata;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".inst"}, inst, m_inst);
    chk({tag, ".ipc"}, inst_pc, m_ipc);
    chk({tag, ".vld"}, {31'd0, inst_valid}, {31'd0, m_valid});
  endtask

  task automatic cyc(input string tag);
    #1;
    for (int k = 0; k < 3; k++)
      chk($sformatf("%s.rd%0d", tag, k), rd_data[k*32 +: 32],
          m_read(rd_addr[k*4 +: 4]));
    @(posedge clk);
    model_edge();
    #1;
    check_state(tag);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0;
    wr_data = '0; fetch_en = 1'b0; branch_valid = 1'b0;
    branch_target = '0; imem_we = 1'b0; imem_waddr = '0;
    imem_wdata = '0;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    check_state("rst0");

    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) begin
      imem_we = 1'b1;
      imem_waddr = 8'(i);
      imem_wdata = (i < 4) ? 32'hE000_0000 + 32'(i) : $urandom;
      cyc("load");
    end
    imem_we = 1'b0;

    rst_n = 1'b0;
    cyc("rstA"); cyc("rstB");
    rst_n = 1'b1; fetch_en = 1'b1;
    cyc("f0");
    chk("f0.inst", inst, 32'hE000_0000);
    chk("f0.ipc", inst_pc, 32'h0);
    chk("f0.vld", {31'd0, inst_valid}, 32'd1);
    cyc("f1");
    chk("f1.inst", inst, 32'hE000_0001);
    chk("f1.ipc", inst_pc, 32'h4);
    cyc("f2");
    chk("f2.inst", inst, 32'hE000_0002);
    chk("f2.ipc", inst_pc, 32'h8);

    fetch_en = 1'b0;
    repeat (3) cyc("stall");
    chk("stall.pc", pc, 32'hC);
    chk("stall.inst", inst, 32'hE000_0002);
    fetch_en = 1'b1;
    cyc("resume");
    chk("resume.inst", inst, 32'hE000_0003);
    chk("resume.ipc", inst_pc, 32'hC);

    branch_valid = 1'b1; branch_target = 32'h0000_000E;
    wr_en = 1'b1; wr_addr = 4'd15; wr_data = 32'h20;
    cyc("br");
    chk("br.pc", pc, 32'hC);
    chk("br.vld", {31'd0, inst_valid}, 32'd0);
    branch_valid = 1'b0; wr_en = 1'b0;
    cyc("brtgt");
    chk("brtgt.inst", inst, 32'hE000_0003);
    chk("brtgt.ipc", inst_pc, 32'hC);

    fetch_en = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'd34;
    rd_addr = {4'd0, 4'd3, 4'd15};
    #1;
    chk("bypass", rd_data[63:32], 32'd34);
    chk("pcread", rd_data[31:0], 32'h18);
    cyc("byp");
    wr_en = 1'b0;
    #1;
    chk("array", rd_data[63:32], 32'd34);
    cyc("arr");

    branch_valid = 1'b1; branch_target = 32'h3FC; fetch_en = 1'b1;
    cyc("b3fc");
    branch_valid = 1'b0;
    cyc("w255");
    chk("w255.inst", inst, m_imem[255]);
    chk("w255.ipc", inst_pc, 32'h3FC);
    cyc("wrap");
    chk("wrap.inst", inst, 32'hE000_0000);
    chk("wrap.ipc", inst_pc, 32'h400);

    imem_we = 1'b1; imem_waddr = 8'd1; imem_wdata = 32'hA5A5_A5A5;
    cyc("rbw");
    chk("rbw.old", inst, 32'hE000_0001);
    imem_we = 1'b0;
    branch_valid = 1'b1; branch_target = 32'h404;
    cyc("rbwbr");
    branch_valid = 1'b0;
    cyc("rbwnew");
    chk("rbw.new", inst, 32'hA5A5_A5A5);

    fetch_en = 1'b0;
    cyc("pre");
    rst_n = 1'b0;
    cyc("rststall");
    chk("rs.pc", pc, 32'h0);
    chk("rs.vld", {31'd0, inst_valid}, 32'd0);
    chk("rs.inst", inst, 32'h0);
    chk("rs.ipc", inst_pc, 32'h0);
    branch_valid = 1'b1; branch_target = 32'h80;
    cyc("rstbr");
    chk("rb.pc", pc, 32'h0);
    branch_valid = 1'b0; rst_n = 1'b1;

    repeat (400) begin
      rst_n = ($urandom_range(0, 49) != 0);
      fetch_en = ($urandom_range(0, 3) != 0);
      branch_valid = ($urandom_range(0, 9) == 0);
      branch_target = $urandom;
      wr_en = $urandom_range(0, 1) == 1;
      wr_addr = 4'($urandom_range(0, 15));
      wr_data = $urandom;
      imem_we = rst_n && ($urandom_range(0, 7) == 0);
      imem_waddr = 8'($urandom_range(0, 255));
      imem_wdata = $urandom;
      rd_addr = 12'($urandom);
      cyc("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
